// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the data cache: FSM states, word type and
// address-field helpers used by the controller and its tag array.
package cache_def;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITE_BACK,
    ALLOCATE
  } dcache_state_t;

  localparam int BYTE_OFF = 2;

  typedef logic [31:0] word_t;

  // Low address bit where the set index starts (byte + word offset).
  function automatic int line_off(input int line_words);
    return BYTE_OFF + $clog2(line_words);
  endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Per-set valid/dirty/tag storage with parallel tag compare, victim choice
// (lowest invalid way, else round-robin) and round-robin pointer upkeep.
module dcache_tag_array
  import cache_def::*;
#(
  parameter int  SETS  = 4,
  parameter int  WAYS  = 2,
  parameter int  TAG_W = 26,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] i_index,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_fill,
  input  logic [WAY_W-1:0] i_fill_way,
  input  logic             i_set_dirty,
  input  logic [WAY_W-1:0] i_dirty_way,
  output logic             o_hit,
  output logic [WAY_W-1:0] o_hit_way,
  output logic [WAY_W-1:0] o_victim_way,
  output logic             o_victim_dirty,
  output logic [TAG_W-1:0] o_victim_tag
);

  logic [WAYS-1:0]  r_valid [SETS];
  logic [WAYS-1:0]  r_dirty [SETS];
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic [WAY_W-1:0] r_rr    [SETS];

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    o_hit        = 1'b0;
    o_hit_way    = '0;
    o_victim_way = r_rr[i_index];
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[i_index][w] && (r_tag[i_index][w] == i_tag)) begin
        o_hit     = 1'b1;
        o_hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[i_index][w]) o_victim_way = WAY_W'(w);
    end
  end

  assign o_victim_dirty = r_valid[i_index][o_victim_way] && r_dirty[i_index][o_victim_way];
  assign o_victim_tag   = r_tag[i_index][o_victim_way];

  // NOTE: state registers use <= so every flop samples pre-edge values together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else if (i_fill) begin
      r_valid[i_index][i_fill_way] <= 1'b1;
      r_dirty[i_index][i_fill_way] <= 1'b0;
      if (i_fill_way == r_rr[i_index]) r_rr[i_index] <= r_rr[i_index] + 1'b1;
    end else if (i_set_dirty) begin
      r_dirty[i_index][i_dirty_way] <= 1'b1;
    end
  end

  // NOTE: tag storage has no reset; the valid bits qualify every entry.
  always_ff @(posedge clk_i) begin
    if (i_fill) r_tag[i_index][i_fill_way] <= i_tag;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate set-associative data cache controller:
// word requests from the core, whole-line transfers to main memory.
module dcache_ctrl
  import cache_def::*;
#(
  parameter int  SETS       = 4,
  parameter int  WAYS       = 2,
  parameter int  LINE_WORDS = 4,
  localparam int LINE_W     = 32 * LINE_WORDS
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_valid_i,
  output logic              cpu_req_ready_o,
  input  logic [31:0]       cpu_req_addr_i,
  input  logic [31:0]       cpu_req_data_i,
  input  logic              cpu_req_rw_i,
  output logic              cpu_res_valid_o,
  output logic [31:0]       cpu_res_data_o,
  output logic              mem_req_valid_o,
  output logic              mem_req_rw_o,
  output logic [31:0]       mem_req_addr_o,
  output logic [LINE_W-1:0] mem_req_data_o,
  input  logic              mem_res_ready_i,
  input  logic [LINE_W-1:0] mem_res_data_i
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int OFF    = line_off(LINE_WORDS);
  localparam int WORD_W = OFF - BYTE_OFF;
  localparam int TAG_W  = 32 - OFF - IDX_W;

  typedef word_t [LINE_WORDS-1:0] line_t;

  dcache_state_t     r_state, w_next;
  logic [31:BYTE_OFF] r_addr;
  word_t             r_wdata;
  logic              r_rw;
  line_t             r_data [SETS][WAYS];

  logic [IDX_W-1:0]  w_index;
  logic [TAG_W-1:0]  w_tag;
  logic [WORD_W-1:0] w_word;
  logic              w_hit, w_victim_dirty, w_fill, w_set_dirty;
  logic [WAY_W-1:0]  w_hit_way, w_victim_way;
  logic [TAG_W-1:0]  w_victim_tag;
  logic              w_unused;

  assign w_index  = r_addr[OFF +: IDX_W];
  assign w_tag    = r_addr[31 -: TAG_W];
  assign w_word   = r_addr[BYTE_OFF +: WORD_W];
  assign w_unused = ^cpu_req_addr_i[BYTE_OFF-1:0];

  dcache_tag_array #(
    .SETS (SETS),
    .WAYS (WAYS),
    .TAG_W(TAG_W)
  ) u_tags (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .i_index       (w_index),
    .i_tag         (w_tag),
    .i_fill        (w_fill),
    .i_fill_way    (w_victim_way),
    .i_set_dirty   (w_set_dirty),
    .i_dirty_way   (w_hit_way),
    .o_hit         (w_hit),
    .o_hit_way     (w_hit_way),
    .o_victim_way  (w_victim_way),
    .o_victim_dirty(w_victim_dirty),
    .o_victim_tag  (w_victim_tag)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rw    <= 1'b0;
    end else if (cpu_req_valid_i && cpu_req_ready_o) begin
      r_addr  <= cpu_req_addr_i[31:BYTE_OFF];
      r_wdata <= cpu_req_data_i;
      r_rw    <= cpu_req_rw_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_fill)           r_data[w_index][w_victim_way]        <= mem_res_data_i;
    else if (w_set_dirty) r_data[w_index][w_hit_way][w_word]   <= r_wdata;
  end

  // Outputs are decoded from state alone, so reset clears them immediately.
  always_comb begin
    w_next          = r_state;
    cpu_req_ready_o = 1'b0;
    cpu_res_valid_o = 1'b0;
    cpu_res_data_o  = '0;
    mem_req_valid_o = 1'b0;
    mem_req_rw_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_data_o  = '0;
    w_fill          = 1'b0;
    w_set_dirty     = 1'b0;
    case (r_state)
      IDLE: begin
        cpu_req_ready_o = 1'b1;
        if (cpu_req_valid_i) w_next = COMPARE;
      end
      COMPARE: begin
        if (w_hit) begin
          cpu_res_valid_o = 1'b1;
          cpu_res_data_o  = r_data[w_index][w_hit_way][w_word];
          w_set_dirty     = r_rw;
          w_next          = IDLE;
        end else if (w_victim_dirty) begin
          w_next = WRITE_BACK;
        end else begin
          w_next = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        mem_req_valid_o = 1'b1;
        mem_req_rw_o    = 1'b1;
        mem_req_addr_o  = {w_victim_tag, w_index, {OFF{1'b0}}};
        mem_req_data_o  = r_data[w_index][w_victim_way];
        if (mem_res_ready_i) w_next = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {w_tag, w_index, {OFF{1'b0}}};
        if (mem_res_ready_i) begin
          w_fill = 1'b1;
          w_next = COMPARE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a line-level cache/memory model predicts
// memory traffic, responses and latency; one process compares every cycle.
module tb_dcache_ctrl;

  localparam int SETS = 4;
  localparam int WAYS = 2;
  localparam int LW   = 4;
  localparam int LINE_W = 32 * LW;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              cpu_req_valid_i;
  logic              cpu_req_ready_o;
  logic [31:0]       cpu_req_addr_i;
  logic [31:0]       cpu_req_data_i;
  logic              cpu_req_rw_i;
  logic              cpu_res_valid_o;
  logic [31:0]       cpu_res_data_o;
  logic              mem_req_valid_o;
  logic              mem_req_rw_o;
  logic [31:0]       mem_req_addr_o;
  logic [LINE_W-1:0] mem_req_data_o;
  logic              mem_res_ready_i;
  logic [LINE_W-1:0] mem_res_data_i;

  dcache_ctrl #(.SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .cpu_req_valid_i(cpu_req_valid_i),
    .cpu_req_ready_o(cpu_req_ready_o),
    .cpu_req_addr_i (cpu_req_addr_i),
    .cpu_req_data_i (cpu_req_data_i),
    .cpu_req_rw_i   (cpu_req_rw_i),
    .cpu_res_valid_o(cpu_res_valid_o),
    .cpu_res_data_o (cpu_res_data_o),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_rw_o   (mem_req_rw_o),
    .mem_req_addr_o (mem_req_addr_o),
    .mem_req_data_o (mem_req_data_o),
    .mem_res_ready_i(mem_res_ready_i),
    .mem_res_data_i (mem_res_data_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { bit rw; logic [31:0] addr; logic [127:0] data; } mem_txn_t;
  typedef struct { bit chk; logic [31:0] data; } res_t;

  mem_txn_t     exp_mem[$];
  res_t         exp_res[$];
  logic [127:0] mem [logic [31:0]];

  bit           m_valid [SETS][WAYS];
  bit           m_dirty [SETS][WAYS];
  logic [25:0]  m_tag   [SETS][WAYS];
  logic [127:0] m_line  [SETS][WAYS];
  int           m_rr    [SETS];

  int           n_checks = 0;
  int           n_pass = 0;
  int           n_rd = 0;
  int           n_wr = 0;
  int           resp_delay = 0;
  bit           hold_mem = 1'b0;
  logic [31:0]  last_rd_addr = '0;
  logic [31:0]  last_wb_addr = '0;
  logic [127:0] last_wb_data = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h, required %0h", name, act, exp);
  endtask

  function automatic logic [127:0] mem_line(input logic [31:0] la);
    if (mem.exists(la)) return mem[la];
    return {la + 32'd12, la + 32'd8, la + 32'd4, la} ^ {4{32'hA5A5_0000}};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
  endtask

  // Predicts memory traffic, response and latency of one request.
  task automatic model_req(input logic [31:0] a, input bit rw, input logic [31:0] wd,
                           input int d, output int lat);
    int idx, wi, h, v;
    logic [25:0] tg;
    logic [31:0] la, wb_a;
    logic [1:0] idx2;
    idx  = int'(a[5:4]);
    idx2 = a[5:4];
    wi   = int'(a[3:2]);
    tg   = a[31:6];
    la   = {a[31:4], 4'h0};
    h    = -1;
    lat  = 1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[idx][w] && m_tag[idx][w] == tg) h = w;
    if (h < 0) begin
      v = m_rr[idx];
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_valid[idx][w]) v = w;
      if (m_valid[idx][v] && m_dirty[idx][v]) begin
        wb_a = {m_tag[idx][v], idx2, 4'h0};
        exp_mem.push_back('{1'b1, wb_a, m_line[idx][v]});
        mem[wb_a] = m_line[idx][v];
        lat += d + 1;
      end
      exp_mem.push_back('{1'b0, la, 128'h0});
      m_line[idx][v]  = mem_line(la);
      m_tag[idx][v]   = tg;
      m_valid[idx][v] = 1'b1;
      m_dirty[idx][v] = 1'b0;
      if (v == m_rr[idx]) m_rr[idx] = (m_rr[idx] + 1) % WAYS;
      lat += d + 2;
      h = v;
    end
    if (rw) begin
      m_line[idx][h][wi*32 +: 32] = wd;
      m_dirty[idx][h] = 1'b1;
    end
    exp_res.push_back('{!rw, m_line[idx][h][wi*32 +: 32]});
  endtask

  // Memory responder and per-cycle output compare.
  int wait_cnt;
  initial begin
    mem_res_ready_i = 1'b0;
    mem_res_data_i  = '0;
    wait_cnt        = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        mem_res_ready_i = 1'b0;
        wait_cnt = 0;
        continue;
      end
      if (mem_res_ready_i) begin
        mem_res_ready_i = 1'b0;
        wait_cnt = 0;
        if (exp_mem.size() != 0) begin
          if (exp_mem[0].rw) n_wr++;
          else n_rd++;
          void'(exp_mem.pop_front());
        end
      end
      if (mem_req_valid_o) begin
        check("mem_req_expected", 128'(exp_mem.size() != 0), 128'd1);
        if (exp_mem.size() != 0) begin
          check("mem_req_rw", 128'(mem_req_rw_o), 128'(exp_mem[0].rw));
          check("mem_req_addr", 128'(mem_req_addr_o), 128'(exp_mem[0].addr));
          if (exp_mem[0].rw) check("mem_req_data", mem_req_data_o, exp_mem[0].data);
          if (!hold_mem) begin
            if (wait_cnt >= resp_delay) begin
              mem_res_ready_i = 1'b1;
              mem_res_data_i  = exp_mem[0].rw ? 128'h0 : mem_line(exp_mem[0].addr);
              if (exp_mem[0].rw) begin
                last_wb_addr = mem_req_addr_o;
                last_wb_data = mem_req_data_o;
              end else begin
                last_rd_addr = mem_req_addr_o;
              end
            end else begin
              wait_cnt++;
            end
          end
        end
      end
      if (cpu_res_valid_o) begin
        check("res_expected", 128'(exp_res.size() != 0), 128'd1);
        if (exp_res.size() != 0) begin
          if (exp_res[0].chk) check("res_data", 128'(cpu_res_data_o), 128'(exp_res[0].data));
          void'(exp_res.pop_front());
        end
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input bit rw, input logic [31:0] wd,
                        input int d, input bit junk, output logic [31:0] rd);
    int lat_exp, lat;
    bit got;
    model_req(a, rw, wd, d, lat_exp);
    resp_delay = d;
    @(negedge clk_i);
    check("req_ready_idle", 128'(cpu_req_ready_o), 128'd1);
    cpu_req_valid_i = 1'b1;
    cpu_req_addr_i  = a;
    cpu_req_rw_i    = rw;
    cpu_req_data_i  = wd;
    @(posedge clk_i);
    #1;
    if (junk) begin
      cpu_req_addr_i = 32'h0000_0200;
      cpu_req_rw_i   = 1'b1;
      cpu_req_data_i = 32'h0BAD_0BAD;
    end else begin
      cpu_req_valid_i = 1'b0;
    end
    lat = 0;
    got = 1'b0;
    rd  = '0;
    while (!got && lat < 300) begin
      @(negedge clk_i);
      lat++;
      if (cpu_res_valid_o) begin
        got = 1'b1;
        rd  = cpu_res_data_o;
      end else if (junk) begin
        check("busy_ready_low", 128'(cpu_req_ready_o), 128'd0);
      end
    end
    cpu_req_valid_i = 1'b0;
    check("resp_seen", 128'(got), 128'd1);
    check("resp_latency", 128'(lat), 128'(lat_exp));
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    bit seen;
    rst_ni          = 1'b0;
    cpu_req_valid_i = 1'b0;
    cpu_req_addr_i  = '0;
    cpu_req_data_i  = '0;
    cpu_req_rw_i    = 1'b0;
    mem[32'h40] = {32'h33, 32'h22, 32'h11, 32'h10};
    model_reset();
    #12;
    check("rst_res_valid", 128'(cpu_res_valid_o), 128'd0);
    check("rst_res_data", 128'(cpu_res_data_o), 128'd0);
    check("rst_mem_valid", 128'(mem_req_valid_o), 128'd0);
    check("rst_mem_rw", 128'(mem_req_rw_o), 128'd0);
    check("rst_mem_addr", 128'(mem_req_addr_o), 128'd0);
    check("rst_mem_data", mem_req_data_o, 128'd0);
    @(negedge clk_i);
    #2 rst_ni = 1'b1;

    // Cold miss into way0, memory answers after 2 wait cycles.
    do_req(32'h40, 1'b0, 32'h0, 2, 1'b0, rd);
    check("t1_data", 128'(rd), 128'h10);
    check("t1_reads", 128'(n_rd), 128'd1);
    check("t1_writes", 128'(n_wr), 128'd0);
    check("t1_rd_addr", 128'(last_rd_addr), 128'h40);

    do_req(32'h44, 1'b0, 32'h0, 0, 1'b0, rd);
    check("t2_data", 128'(rd), 128'h11);
    check("t2_reads", 128'(n_rd), 128'd1);

    do_req(32'h48, 1'b1, 32'hDEADBEEF, 0, 1'b0, rd);
    do_req(32'h48, 1'b0, 32'h0, 0, 1'b0, rd);
    check("t3_data", 128'(rd), 128'hDEADBEEF);
    check("t3_reads", 128'(n_rd), 128'd1);
    check("t3_writes", 128'(n_wr), 128'd0);

    do_req(32'h80, 1'b0, 32'h0, 1, 1'b0, rd);
    check("t4_clean_data", 128'(rd), 128'hA5A5_0080);
    check("t4_clean_writes", 128'(n_wr), 128'd0);

    // Dirty eviction of way0 with a slow memory and CPU requests meanwhile.
    do_req(32'hC0, 1'b0, 32'h0, 5, 1'b1, rd);
    check("t4_wb_addr", 128'(last_wb_addr), 128'h40);
    check("t4_wb_data", last_wb_data, {32'h33, 32'hDEADBEEF, 32'h11, 32'h10});
    check("t4_writes", 128'(n_wr), 128'd1);
    check("t4_rd_addr", 128'(last_rd_addr), 128'hC0);
    check("t4_data", 128'(rd), 128'hA5A5_00C0);

    // rr[0] now points at way1 (clean 0x80): no write-back expected.
    do_req(32'h100, 1'b0, 32'h0, 0, 1'b0, rd);
    check("t4_rr_data", 128'(rd), 128'hA5A5_0100);
    check("t4_rr_writes", 128'(n_wr), 128'd1);

    // Reset while ALLOCATE is waiting on memory.
    hold_mem = 1'b1;
    exp_mem.push_back('{1'b0, 32'h140, 128'h0});
    @(negedge clk_i);
    cpu_req_valid_i = 1'b1;
    cpu_req_addr_i  = 32'h140;
    cpu_req_rw_i    = 1'b0;
    @(posedge clk_i);
    #1 cpu_req_valid_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_i);
      seen = mem_req_valid_o;
    end
    check("t6_alloc_seen", 128'(seen), 128'd1);
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    check("t6_rst_mem_valid", 128'(mem_req_valid_o), 128'd0);
    check("t6_rst_mem_addr", 128'(mem_req_addr_o), 128'd0);
    check("t6_rst_res_valid", 128'(cpu_res_valid_o), 128'd0);
    exp_mem.delete();
    exp_res.delete();
    model_reset();
    hold_mem = 1'b0;
    @(negedge clk_i);
    #2 rst_ni = 1'b1;

    do_req(32'h44, 1'b0, 32'h0, 1, 1'b0, rd);
    check("t6_data", 128'(rd), 128'h11);
    check("t6_rd_addr", 128'(last_rd_addr), 128'h40);
    check("t6_writes", 128'(n_wr), 128'd1);
    do_req(32'h48, 1'b0, 32'h0, 0, 1'b0, rd);
    check("t6_wb_merged", 128'(rd), 128'hDEADBEEF);

    repeat (2) @(negedge clk_i);
    check("end_mem_queue", 128'(exp_mem.size()), 128'd0);
    check("end_res_queue", 128'(exp_res.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
